// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Inhibits the bus, issues request-to-send, then shifts a byte out on device-generated clock edges.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             clk_low_q, clk_low_d;
  logic             data_low_q, data_low_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_s3_q, clk_s3_d;
  logic             data_s1_q, data_s1_d, data_s2_q, data_s2_d;

  logic ps2_fall;
  logic active;

  // clk_s3_q is the previous synchronized clock sample, used only for edge detection
  assign ps2_fall = clk_s3_q & ~clk_s2_q;
  assign active   = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP) ||
                    (state_q == ACK)  || (state_q == WAIT_IDLE);

  always_comb begin
    clk_s1_d   = ps2_clk_in;
    clk_s2_d   = clk_s1_q;
    clk_s3_d   = clk_s2_q;
    data_s1_d  = ps2_data_in;
    data_s2_d  = data_s1_q;
    state_d    = state_q;
    data_d     = data_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    if (active && (tmo_cnt_q != TMO_MAX)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        busy_d     = 1'b0;
        if (start) begin
          data_d    = data_in;
          parity_d  = ~^data_in;
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          tmo_cnt_d = '0;
          clk_low_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        if (inh_cnt_q == INH_LAST) begin
          data_low_d = 1'b1;
          state_d    = RTS;
        end
      end
      RTS: begin
        clk_low_d = 1'b0;
        tmo_cnt_d = '0;
        state_d   = DATA;
      end
      DATA: begin
        if (ps2_fall) begin
          data_low_d = ~data_q[bit_cnt_q];
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (ps2_fall) begin
          data_low_d = ~parity_q;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (ps2_fall) begin
          data_low_d = 1'b0;
          state_d    = ACK;
        end
      end
      ACK: begin
        if (ps2_fall) begin
          if (!data_s2_q) begin
            state_d = WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_s2_q && data_s2_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timeout overrides any same-cycle completion so done and error stay exclusive
    if (active && (tmo_cnt_q >= TMO_LAST)) begin
      state_d    = IDLE;
      clk_low_d  = 1'b0;
      data_low_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_s3_q   <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_s3_q   <= clk_s3_d;
      data_s1_q  <= data_s1_d;
      data_s2_q  <= data_s2_d;
    end
  end

  assign ps2_clk_low  = clk_low_q;
  assign ps2_data_low = data_low_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with an open-drain PS/2 device model
// The device drives its own clock and reads the wire-AND data line before each falling edge.
module tb_ps2_host_tx;

  localparam int INH = 10;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_low, ps2_data_low, busy, done, error;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int viol_cnt = 0;
  logic busy_prev = 1'b0;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_low;
  assign ps2_data_in = dev_data & ~ps2_data_low;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_low(ps2_clk_low), .ps2_data_low(ps2_data_low),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
    if ((done && error) || ((done || error) && (busy || !busy_prev))) viol_cnt <= viol_cnt + 1;
    busy_prev <= busy;
  end

  task automatic do_start(input logic [7:0] b);
    @(negedge clk);
    data_in = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_release(output int inh_n, output int rts_n, output bit ok);
    inh_n = 0; rts_n = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ps2_clk_low && !ps2_data_low) inh_n++;
      else if (ps2_clk_low && ps2_data_low) rts_n++;
      else if (inh_n > 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic dev_clock(input int n_edges, input bit ack, output logic [10:0] bits);
    bits = '0;
    for (int i = 0; i < n_edges; i++) begin
      repeat (8) @(negedge clk);
      bits[i] = ps2_data_in;
      if (i == 10 && ack) dev_data = 1'b0;
      repeat (4) @(negedge clk);
      dev_clk = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b1;
    end
    repeat (4) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ps2_clk_low !== 1'b0) begin errors++; $display("FAIL reset_clk_low: got %b expected 0", ps2_clk_low); end
    checks++; if (ps2_data_low !== 1'b0) begin errors++; $display("FAIL reset_data_low: got %b expected 0", ps2_data_low); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%b error=%b expected 0 0", done, error); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_edges();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 6; i++) begin
      dev_clk = 1'b0; dev_data = i[0];
      repeat (6) @(negedge clk);
      dev_clk = 1'b1;
      repeat (6) @(negedge clk);
    end
    dev_data = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0 || ps2_clk_low !== 1'b0 || ps2_data_low !== 1'b0) begin
      errors++; $display("FAIL idle_edges: got busy=%b clk_low=%b data_low=%b expected 0 0 0", busy, ps2_clk_low, ps2_data_low); end
    checks++; if (done_cnt != d0 || err_cnt != e0) begin
      errors++; $display("FAIL idle_pulses: got done=%0d error=%0d expected 0 0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_send(input logic [7:0] b, input logic par, input string nm);
    int inh_n, rts_n, d0, e0, v0;
    bit ok;
    logic [10:0] bits, exp;
    d0 = done_cnt; e0 = err_cnt; v0 = viol_cnt;
    exp = {1'b1, par, b, 1'b0};
    do_start(b);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_start: got %b expected 1", nm, busy); end
    wait_release(inh_n, rts_n, ok);
    checks++; if (inh_n != INH) begin errors++; $display("FAIL %s_inhibit: got %0d expected %0d", nm, inh_n, INH); end
    checks++; if (rts_n != 1 || !ok) begin errors++; $display("FAIL %s_rts: got rts=%0d released=%0b expected 1 1", nm, rts_n, ok); end
    dev_clock(11, 1'b1, bits);
    repeat (10) @(negedge clk);
    checks++; if (bits !== exp) begin errors++; $display("FAIL %s_bits: got %b expected %b", nm, bits, exp); end
    checks++; if (done_cnt - d0 != 1 || err_cnt != e0) begin
      errors++; $display("FAIL %s_pulses: got done=%0d error=%0d expected 1 0", nm, done_cnt - d0, err_cnt - e0); end
    checks++; if (busy !== 1'b0 || ps2_clk_low !== 1'b0 || ps2_data_low !== 1'b0) begin
      errors++; $display("FAIL %s_end: got busy=%b clk_low=%b data_low=%b expected 0 0 0", nm, busy, ps2_clk_low, ps2_data_low); end
    checks++; if (viol_cnt != v0) begin errors++; $display("FAIL %s_pulse_rules: got %0d violations expected 0", nm, viol_cnt - v0); end
  endtask

  task automatic test_nack();
    int inh_n, rts_n, d0, e0, v0;
    bit ok;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt; v0 = viol_cnt;
    do_start(8'h55);
    wait_release(inh_n, rts_n, ok);
    dev_clock(11, 1'b0, bits);
    repeat (10) @(negedge clk);
    checks++; if (err_cnt - e0 != 1 || done_cnt != d0) begin
      errors++; $display("FAIL nack_pulses: got done=%0d error=%0d expected 0 1", done_cnt - d0, err_cnt - e0); end
    checks++; if (busy !== 1'b0 || ps2_clk_low !== 1'b0 || ps2_data_low !== 1'b0) begin
      errors++; $display("FAIL nack_end: got busy=%b clk_low=%b data_low=%b expected 0 0 0", busy, ps2_clk_low, ps2_data_low); end
    checks++; if (viol_cnt != v0) begin errors++; $display("FAIL nack_pulse_rules: got %0d violations expected 0", viol_cnt - v0); end
  endtask

  task automatic test_timeout();
    int inh_n, rts_n, d0, e0, k;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    do_start(8'h12);
    wait_release(inh_n, rts_n, ok);
    k = 0;
    for (int i = 0; i < TMO + 50; i++) begin
      @(negedge clk);
      k++;
      if (error) break;
    end
    checks++; if (k != TMO || error !== 1'b1) begin errors++; $display("FAIL timeout_latency: got %0d cycles error=%b expected %0d 1", k, error, TMO); end
    checks++; if (ps2_clk_low !== 1'b0 || ps2_data_low !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_release: got clk_low=%b data_low=%b busy=%b expected 0 0 0", ps2_clk_low, ps2_data_low, busy); end
    repeat (5) @(negedge clk);
    checks++; if (err_cnt - e0 != 1 || done_cnt != d0) begin
      errors++; $display("FAIL timeout_pulses: got done=%0d error=%0d expected 0 1", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    int inh_n, rts_n, d0, e0;
    bit ok;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    do_start(8'hF4);
    start = 1'b1;
    data_in = 8'hFF;
    wait_release(inh_n, rts_n, ok);
    start = 1'b0;
    dev_clock(11, 1'b1, bits);
    repeat (10) @(negedge clk);
    checks++; if (bits !== 11'b1_0_11110100_0) begin errors++; $display("FAIL b2b_bits: got %b expected %b", bits, 11'b1_0_11110100_0); end
    checks++; if (done_cnt - d0 != 1 || err_cnt != e0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_pulses: got done=%0d error=%0d busy=%b expected 1 0 0", done_cnt - d0, err_cnt - e0, busy); end
  endtask

  task automatic test_reset_abort();
    int inh_n, rts_n, d0, e0;
    bit ok;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    do_start(8'hA5);
    wait_release(inh_n, rts_n, ok);
    dev_clock(4, 1'b0, bits);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ps2_clk_low !== 1'b0 || ps2_data_low !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_state: got clk_low=%b data_low=%b busy=%b expected 0 0 0", ps2_clk_low, ps2_data_low, busy); end
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0; repeat (10) @(negedge clk);
      dev_clk = 1'b1; repeat (10) @(negedge clk);
    end
    checks++; if (done_cnt != d0 || err_cnt != e0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_pulses: got done=%0d error=%0d busy=%b expected 0 0 0", done_cnt - d0, err_cnt - e0, busy); end
    test_send(8'h3C, 1'b1, "after_abort");
  endtask

  initial begin
    test_reset();
    test_idle_edges();
    test_send(8'hED, 1'b1, "ed");
    test_send(8'h00, 1'b1, "x00");
    test_send(8'h07, 1'b0, "x07");
    test_nack();
    test_timeout();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clk cycles the PS/2 clock is held low before request-to-send (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, maximum clk cycles from clock release to end of transfer (20 ms at 50 MHz).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to send data_in; accepted only when busy=0.
REQ-006 data_in  input  8  command byte to transmit to the device.
REQ-007 ps2_clk_in  input  1  PS/2 clock line as read at the pad (asynchronous).
REQ-008 ps2_data_in  input  1  PS/2 data line as read at the pad (asynchronous).
REQ-009 ps2_clk_low  output  1  1 = drive PS/2 clock low; 0 = release (open-drain, pulled high externally).
REQ-010 ps2_data_low  output  1  1 = drive PS/2 data low; 0 = release.
REQ-011 busy  output  1  high from accepted start until done or error pulse.
REQ-012 done  output  1  one-cycle pulse: byte sent and device ACK received.
REQ-013 error  output  1  one-cycle pulse: ACK missing or timeout.

Function
REQ-014 ps2_clk_in and ps2_data_in SHALL each pass through a 2-flop synchronizer; a PS/2 falling edge is synchronized clock 1 previous cycle, 0 current cycle.
REQ-015 All outputs SHALL be registered.
REQ-016 States: IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-017 IDLE: lines released, busy=0; start=1 latches data_in and odd parity (~^data_in), clears counters, next state INHIBIT.
REQ-018 INHIBIT: ps2_clk_low=1 for exactly INHIBIT_CYCLES cycles, then RTS.
REQ-019 RTS: ps2_data_low=1 (start bit) with ps2_clk_low still 1 for one cycle; then ps2_clk_low=0, timeout counter starts, next state DATA.
REQ-020 DATA: on each PS/2 falling edge drive next bit LSB first (ps2_data_low = ~bit); after the 8th bit is driven, go to PARITY.
REQ-021 PARITY: on next falling edge drive parity bit (ps2_data_low = ~parity), go to STOP.
REQ-022 STOP: on next falling edge release data (ps2_data_low=0), go to ACK.
REQ-023 ACK: on next falling edge sample synchronized data; 0 -> WAIT_IDLE; 1 -> error pulse, IDLE.
REQ-024 WAIT_IDLE: when synchronized clock and data both 1, pulse done, go to IDLE.
REQ-025 Falling edges outside DATA/PARITY/STOP/ACK SHALL be ignored.
REQ-026 start while busy=1 SHALL be ignored; data_in is not re-latched.
REQ-027 Timeout counter saturates; reaching TIMEOUT_CYCLES in DATA..WAIT_IDLE releases both lines, pulses error, returns to IDLE.
REQ-028 done and error SHALL never assert in the same cycle; each pulses exactly once per accepted start.
REQ-029 busy SHALL fall in the same cycle done or error is high.

Reset
REQ-030 reset=1 on a rising clk edge forces IDLE from any state, mid-transfer included.
REQ-031 Reset values: ps2_clk_low=0, ps2_data_low=0, busy=0, done=0, error=0, bit counter=0, timeout counter=0, synchronizer flops=1.
REQ-032 No done or error pulse SHALL follow a reset-aborted transfer.

Verification
REQ-033 Send 0xED, device model clocks 11 edges and ACKs -> bits observed on line 0,1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; busy low after.
REQ-034 Send 0x00 -> parity bit 1; send 0x07 -> parity bit 0; both complete with done.
REQ-035 Device leaves data high at ACK edge -> error pulses once, no done, both lines released.
REQ-036 Device never clocks after RTS -> error exactly TIMEOUT_CYCLES cycles after clock release; lines released.
REQ-037 start=1 with 0xFF during busy of 0xF4 transfer -> 0xF4 bits on line only, one done.
REQ-038 reset after 4th data bit -> next cycle both lines released, busy=0, no done/error; new start then transfers normally.
